// File: rtl/clint_trap_ctrl.sv
// Core-local trap sequencer: takes ecall/ebreak/mret and enabled timer/external
// interrupts from decode, drains the pipe, writes mepc/mcause/mstatus, then redirects.
module clint_trap_ctrl #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MIE_ADDR     = 12'h304,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  exc_status,
    input  logic [31:0] inst_addr,
    input  logic        id_valid,
    input  logic        pipe_empty,
    input  logic        timer_irq,
    input  logic        ext_irq,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mie,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        hold_flag_id,
    output logic        int_csr_we,
    output logic [11:0] int_csr_waddr,
    output logic [31:0] int_csr_wdata,
    output logic        int_redirect,
    output logic [31:0] int_target
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic        mret_q, mret_d;

    logic        timer_en;
    logic        ext_en;
    logic        sync_evt;
    logic        accept;
    logic [31:0] mstatus_trap;
    logic [31:0] mstatus_mret;

    // MIE_ADDR is documentation only; mie arrives as an input rather than being written.
    logic unused_bits;
    assign unused_bits = ^{MIE_ADDR, csr_mie[31:12], csr_mie[10:8], csr_mie[6:0],
                           csr_mtvec[1:0], inst_addr[1:0]};

    always_comb begin
        timer_en = timer_irq & csr_mie[7]  & csr_mstatus[3];
        ext_en   = ext_irq   & csr_mie[11] & csr_mstatus[3];
        sync_evt = (exc_status != 2'b00);
        // Gating with rst_n keeps hold_flag_id low while reset is held.
        accept   = rst_n & id_valid & (state_q == S_IDLE) & (sync_evt | ext_en | timer_en);

        mstatus_trap        = csr_mstatus;
        mstatus_trap[7]     = csr_mstatus[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;

        mstatus_mret        = csr_mstatus;
        mstatus_mret[3]     = csr_mstatus[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;
    end

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        mret_d        = mret_q;
        hold_flag_id  = 1'b0;
        int_csr_we    = 1'b0;
        int_csr_waddr = 12'h000;
        int_csr_wdata = 32'h0000_0000;
        int_redirect  = 1'b0;
        int_target    = 32'h0000_0000;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hold_flag_id = 1'b1;
                    state_d      = S_DRAIN;
                    epc_d        = inst_addr[31:2];
                    mret_d       = (exc_status == 2'b11);
                    if (exc_status == 2'b01)      cause_d = 32'd11;
                    else if (exc_status == 2'b10) cause_d = 32'd3;
                    else if (exc_status == 2'b11) cause_d = 32'd0;
                    else if (ext_en)              cause_d = 32'h8000_000B;
                    else                          cause_d = 32'h8000_0007;
                end
            end
            S_DRAIN: begin
                hold_flag_id = 1'b1;
                if (pipe_empty) state_d = mret_q ? S_W_MSTATUS : S_W_MEPC;
            end
            S_W_MEPC: begin
                hold_flag_id  = 1'b1;
                int_csr_we    = 1'b1;
                int_csr_waddr = MEPC_ADDR;
                int_csr_wdata = {epc_q, 2'b00};
                state_d       = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                hold_flag_id  = 1'b1;
                int_csr_we    = 1'b1;
                int_csr_waddr = MCAUSE_ADDR;
                int_csr_wdata = cause_q;
                state_d       = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                hold_flag_id  = 1'b1;
                int_csr_we    = 1'b1;
                int_csr_waddr = MSTATUS_ADDR;
                int_csr_wdata = mret_q ? mstatus_mret : mstatus_trap;
                state_d       = S_REDIRECT;
            end
            S_REDIRECT: begin
                hold_flag_id = 1'b1;
                int_redirect = 1'b1;
                int_target   = mret_q ? csr_mepc : {csr_mtvec[31:2], 2'b00};
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mret_q  <= mret_d;
        end
    end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Bench for clint_trap_ctrl: directed scenarios plus random ones, each checked
// cycle by cycle against a transaction-level model of the trap sequence.
module tb_clint_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  exc_status;
    logic [31:0] inst_addr;
    logic        id_valid;
    logic        pipe_empty;
    logic        timer_irq;
    logic        ext_irq;
    logic [31:0] csr_mstatus;
    logic [31:0] csr_mie;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        hold_flag_id;
    logic        int_csr_we;
    logic [11:0] int_csr_waddr;
    logic [31:0] int_csr_wdata;
    logic        int_redirect;
    logic [31:0] int_target;

    typedef struct packed {
        logic        hold;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        redir;
        logic [31:0] target;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks;
    int   n_errors;

    clint_trap_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .exc_status    (exc_status),
        .inst_addr     (inst_addr),
        .id_valid      (id_valid),
        .pipe_empty    (pipe_empty),
        .timer_irq     (timer_irq),
        .ext_irq       (ext_irq),
        .csr_mstatus   (csr_mstatus),
        .csr_mie       (csr_mie),
        .csr_mtvec     (csr_mtvec),
        .csr_mepc      (csr_mepc),
        .hold_flag_id  (hold_flag_id),
        .int_csr_we    (int_csr_we),
        .int_csr_waddr (int_csr_waddr),
        .int_csr_wdata (int_csr_wdata),
        .int_redirect  (int_redirect),
        .int_target    (int_target)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_obs(input string tag, input obs_t e);
        check({tag, ".hold"},   32'(hold_flag_id),  32'(e.hold));
        check({tag, ".we"},     32'(int_csr_we),    32'(e.we));
        check({tag, ".waddr"},  32'(int_csr_waddr), 32'(e.waddr));
        check({tag, ".wdata"},  int_csr_wdata,      e.wdata);
        check({tag, ".redir"},  32'(int_redirect),  32'(e.redir));
        check({tag, ".target"}, int_target,         e.target);
    endtask

    // ---------------- reference model ----------------
    // Builds the full expected output trace of one scenario. pipe_empty is low
    // for the first d cycles counted from the acceptance cycle.
    task automatic model_scn(input logic [1:0] exc, input logic tirq, input logic eirq,
                             input logic [31:0] mie, input logic [31:0] mst,
                             input logic [31:0] mtvec, input logic [31:0] mepc,
                             input logic [31:0] addr, input logic idv, input int d);
        obs_t o;
        logic t_en, e_en, mret;
        logic [31:0] cause, new_mst;
        int drain_len;
        t_en = tirq & mie[7] & mst[3];
        e_en = eirq & mie[11] & mst[3];
        o = '0;
        if (!(idv && (exc != 2'b00 || t_en || e_en))) begin
            exp_q.push_back(o);
            return;
        end
        mret  = (exc == 2'b11);
        cause = (exc == 2'b01) ? 32'd11 :
                (exc == 2'b10) ? 32'd3 :
                e_en           ? 32'h8000_000B : 32'h8000_0007;
        drain_len = (d < 1) ? 1 : d;
        o.hold = 1'b1;
        exp_q.push_back(o);
        for (int i = 0; i < drain_len; i++) exp_q.push_back(o);
        o.we = 1'b1;
        if (!mret) begin
            o.waddr = 12'h341; o.wdata = addr & 32'hFFFF_FFFC; exp_q.push_back(o);
            o.waddr = 12'h342; o.wdata = cause;                exp_q.push_back(o);
        end
        if (mret) new_mst = (mst & ~32'h8) | (mst[7] ? 32'h8 : 32'h0) | 32'h1880;
        else      new_mst = (mst & ~32'h88) | (mst[3] ? 32'h80 : 32'h0) | 32'h1800;
        o.waddr = 12'h300; o.wdata = new_mst;
        exp_q.push_back(o);
        o = '0;
        o.hold   = 1'b1;
        o.redir  = 1'b1;
        o.target = mret ? mepc : (mtvec & 32'hFFFF_FFFC);
        exp_q.push_back(o);
    endtask

    // ---------------- driver ----------------
    // Scenario inputs apply in the acceptance cycle; afterwards decode-side
    // inputs get random noise, which the block must ignore.
    task automatic run_scn(input string tag, input logic [1:0] exc, input logic tirq,
                           input logic eirq, input logic [31:0] mie, input logic [31:0] mst,
                           input logic [31:0] mtvec, input logic [31:0] mepc,
                           input logic [31:0] addr, input logic idv, input int d);
        int n;
        obs_t e;
        exp_q.delete();
        model_scn(exc, tirq, eirq, mie, mst, mtvec, mepc, addr, idv, d);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            csr_mie     = mie;
            csr_mstatus = mst;
            csr_mtvec   = mtvec;
            csr_mepc    = mepc;
            pipe_empty  = (k >= d);
            if (k == 0) begin
                exc_status = exc;
                timer_irq  = tirq;
                ext_irq    = eirq;
                inst_addr  = addr;
                id_valid   = idv;
            end else begin
                exc_status = 2'($urandom_range(0, 3));
                timer_irq  = 1'($urandom_range(0, 1));
                ext_irq    = 1'($urandom_range(0, 1));
                inst_addr  = $urandom;
                id_valid   = 1'($urandom_range(0, 1));
            end
            #1;
            e = exp_q.pop_front();
            check_obs($sformatf("%s.c%0d", tag, k), e);
        end
    endtask

    task automatic idle_inputs();
        exc_status  = 2'b00;
        inst_addr   = 32'h0;
        id_valid    = 1'b0;
        pipe_empty  = 1'b1;
        timer_irq   = 1'b0;
        ext_irq     = 1'b0;
        csr_mstatus = 32'h0;
        csr_mie     = 32'h0;
        csr_mtvec   = 32'h0;
        csr_mepc    = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        obs_t z;
        z = '0;
        check_obs(tag, z);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        // Event pending during reset: outputs must still read zero.
        exc_status = 2'b01;
        id_valid   = 1'b1;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        run_scn("ecall",   2'b01, 1'b0, 1'b0, 32'h0,   32'h8,    32'h800, 32'h0, 32'h104, 1'b1, 0);
        run_scn("timer",   2'b00, 1'b1, 1'b0, 32'h80,  32'h8,    32'h800, 32'h0, 32'h200, 1'b1, 3);
        run_scn("tim_mie0",2'b00, 1'b1, 1'b0, 32'h80,  32'h0,    32'h800, 32'h0, 32'h200, 1'b1, 0);
        run_scn("tim_ie0", 2'b00, 1'b1, 1'b0, 32'h0,   32'h8,    32'h800, 32'h0, 32'h200, 1'b1, 0);
        run_scn("ebreak",  2'b10, 1'b1, 1'b1, 32'h880, 32'h8,    32'h800, 32'h0, 32'h300, 1'b1, 1);
        run_scn("reenter", 2'b00, 1'b1, 1'b1, 32'h880, 32'h1880, 32'h800, 32'h0, 32'h304, 1'b1, 0);
        run_scn("ext",     2'b00, 1'b1, 1'b1, 32'h880, 32'h8,    32'h903, 32'h0, 32'h40a, 1'b1, 2);
        run_scn("noval",   2'b01, 1'b1, 1'b1, 32'h880, 32'h8,    32'h800, 32'h0, 32'h100, 1'b0, 0);
        run_scn("mret",    2'b11, 1'b0, 1'b0, 32'h0,   32'h1880, 32'h800, 32'h104, 32'h500, 1'b1, 0);
        run_scn("b2b",     2'b01, 1'b0, 1'b0, 32'h0,   32'h0,    32'h800, 32'h0, 32'h600, 1'b1, 0);

        // Reset asserted mid-sequence while W_MCAUSE drives its write.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exc_status  = 2'b01;
            id_valid    = 1'b1;
            inst_addr   = 32'h104;
            pipe_empty  = 1'b1;
            csr_mstatus = 32'h8;
            csr_mtvec   = 32'h800;
        end
        #1;
        check("rst_mid.we_before",    32'(int_csr_we),    32'd1);
        check("rst_mid.waddr_before", 32'(int_csr_waddr), 32'h342);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid.async");
        @(posedge clk);
        #1;
        check_all_zero("rst_mid.held");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check_all_zero($sformatf("rst_after.c%0d", k));
        end
        run_scn("post_rst", 2'b10, 1'b0, 1'b0, 32'h0, 32'h8, 32'h1000, 32'h0, 32'h700, 1'b1, 0);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  exc;
            logic [31:0] mst;
            int          r;
            r   = $urandom_range(0, 7);
            exc = (r < 4) ? 2'b00 : 2'(r - 4);
            mst = $urandom;
            run_scn($sformatf("rnd%0d", i), exc, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, mst, $urandom, $urandom,
                    $urandom, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 4));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
